// File: rtl/fft_spectrum_ctrl.sv
// fft_spectrum_ctrl
//
// Frame controller placed after the FFT modulus stage. It checks the framing
// of the incoming magnitude stream and stores the lower STORE_LEN bins of
// every good frame. While storing, it tracks the peak bin, with DC excluded.
// It then drains the stored bins to a consumer over valid/ready. Frames that
// start while a drain is in progress are dropped and counted, so the consumer
// never sees a mix of two spectra.
//
// Ports
//   clk_50m       system clock
//   rst_n         synchronous, active-low reset
//   data_modulus  magnitude of the current input bin (DW bits, unsigned)
//   data_sop      first bin of a frame, qualified by data_valid
//   data_eop      last bin of a frame, qualified by data_valid
//   data_valid    input beat valid (no backpressure on the input side)
//   out_data      stored magnitude being presented
//   out_bin       bin index of out_data
//   out_valid     output beat valid
//   out_last      high together with bin STORE_LEN-1
//   out_ready     consumer accepts the current beat
//   peak_mag      peak magnitude of the last good frame (bins 1..STORE_LEN-1)
//   peak_bin      bin index of peak_mag
//   frame_done    one-cycle pulse when a good frame has been captured
//   frame_err     one-cycle pulse when a malformed frame is detected
//   drop_cnt      saturating count of frames dropped during a drain
`timescale 1ns/1ps

module fft_spectrum_ctrl #(
  parameter int FFT_LEN   = 128,
  parameter int STORE_LEN = 64,
  parameter int DW        = 12,
  parameter int AW        = 7
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic [DW-1:0] data_modulus,
  input  logic          data_sop,
  input  logic          data_eop,
  input  logic          data_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_bin,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic [DW-1:0] peak_mag,
  output logic [AW-1:0] peak_bin,
  output logic          frame_done,
  output logic          frame_err,
  output logic [7:0]    drop_cnt
);

  // Buffer address width; STORE_LEN never exceeds FFT_LEN, so SW <= AW.
  localparam int            SW        = (STORE_LEN > 1) ? $clog2(STORE_LEN) : 1;
  localparam logic [AW-1:0] LAST_BIN  = AW'(FFT_LEN - 1);
  localparam logic [AW-1:0] LAST_OUT  = AW'(STORE_LEN - 1);
  localparam logic [AW:0]   STORE_LIM = (AW+1)'(STORE_LEN);

  typedef enum logic [1:0] {WAIT_SOP, CAPTURE, DRAIN} state_t;

  state_t        state_reg;
  logic [AW-1:0] bin_cnt_reg;
  logic [DW-1:0] run_mag_reg;
  logic [AW-1:0] run_bin_reg;
  logic [AW-1:0] rd_addr_reg;   // next bin to fetch from the buffer

  logic [DW-1:0] mem [STORE_LEN];

  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic          peak_hit;
  logic          last_hs;
  logic          rd_en;

  // Buffer write and peak qualification for the current input beat.
  // A sop always lands in bin 0, whether it opens a frame or restarts one.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = bin_cnt_reg[SW-1:0];
    peak_hit = 1'b0;
    if (data_valid) begin
      if (state_reg == WAIT_SOP && data_sop) begin
        wr_en   = 1'b1;
        wr_addr = '0;
      end else if (state_reg == CAPTURE) begin
        if (data_sop) begin
          wr_en   = 1'b1;
          wr_addr = '0;
        end else begin
          // bin_cnt_reg is at least 1 here, so DC never competes for the peak.
          wr_en    = ({1'b0, bin_cnt_reg} < STORE_LIM);
          peak_hit = wr_en && (data_modulus > run_mag_reg);
        end
      end
    end
  end

  // The output register is refilled whenever it is empty or being consumed.
  // With the read address already pointing at the next bin, this sustains
  // one beat per cycle while out_ready stays high.
  assign last_hs = out_valid && out_ready && out_last;
  assign rd_en   = (state_reg == DRAIN) && !last_hs && (!out_valid || out_ready);

  always_ff @(posedge clk_50m) begin
    if (wr_en) begin
      mem[wr_addr] <= data_modulus;
    end
  end

  // Registered buffer read feeds out_data directly.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (rd_en) begin
      out_data <= mem[rd_addr_reg[SW-1:0]];
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_reg   <= WAIT_SOP;
      bin_cnt_reg <= '0;
      run_mag_reg <= '0;
      run_bin_reg <= '0;
      rd_addr_reg <= '0;
      out_bin     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      peak_mag    <= '0;
      peak_bin    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state_reg)
        WAIT_SOP: begin
          if (data_valid && data_sop) begin
            if (data_eop) begin
              frame_err <= 1'b1;
            end else begin
              bin_cnt_reg <= AW'(1);
              run_mag_reg <= '0;
              run_bin_reg <= '0;
              state_reg   <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          if (data_valid) begin
            if (data_sop) begin
              // Restart on this beat; a restart that is also an eop is a
              // one-beat frame and therefore malformed as well.
              frame_err <= 1'b1;
              if (data_eop) begin
                state_reg <= WAIT_SOP;
              end else begin
                bin_cnt_reg <= AW'(1);
                run_mag_reg <= '0;
                run_bin_reg <= '0;
              end
            end else begin
              if (peak_hit) begin
                run_mag_reg <= data_modulus;
                run_bin_reg <= bin_cnt_reg;
              end
              if (data_eop && bin_cnt_reg == LAST_BIN) begin
                frame_done  <= 1'b1;
                peak_mag    <= peak_hit ? data_modulus : run_mag_reg;
                peak_bin    <= peak_hit ? bin_cnt_reg : run_bin_reg;
                rd_addr_reg <= '0;
                state_reg   <= DRAIN;
              end else if (data_eop || bin_cnt_reg == LAST_BIN) begin
                frame_err <= 1'b1;
                state_reg <= WAIT_SOP;
              end else begin
                bin_cnt_reg <= bin_cnt_reg + AW'(1);
              end
            end
          end
        end

        DRAIN: begin
          if (data_valid && data_sop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
          if (last_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state_reg <= WAIT_SOP;
          end else if (rd_en) begin
            out_valid   <= 1'b1;
            out_bin     <= rd_addr_reg;
            out_last    <= (rd_addr_reg == LAST_OUT);
            rd_addr_reg <= rd_addr_reg + AW'(1);
          end
        end

        default: state_reg <= WAIT_SOP;
      endcase
    end
  end

endmodule

// File: doc/fft_spectrum_ctrl.md
Name: fft_spectrum_ctrl

Overview:
Frame controller that follows the modulus stage of the FFT chain. It accepts the magnitude stream (data_modulus with sop/eop/valid) and checks frame integrity. It captures the lower STORE_LEN bins of each good frame into an internal buffer and tracks the peak bin. It then drains the buffer to a downstream consumer (display/UART) over a valid/ready handshake. While a frame is being drained, any new frame is dropped and counted, so the downstream side never sees a torn spectrum.

Parameters:
FFT_LEN, 128, points per FFT frame (power of 2, at least 4)
STORE_LEN, 64, bins stored and output (2 to FFT_LEN); 64 keeps the non-redundant half for real input
DW, 12, magnitude width
AW, 7, bin index width, equal to clog2(FFT_LEN)

Ports:
clk_50m  in  1  system clock
rst_n  in  1  reset; synchronous and active-low
data_modulus  in  DW  unsigned magnitude of the current bin
data_sop  in  1  first bin of frame; qualified by data_valid
data_eop  in  1  last bin of frame; qualified by data_valid
data_valid  in  1  input beat valid; there is no backpressure on the input
out_data  out  DW  stored magnitude
out_bin  out  AW  bin index of out_data
out_valid  out  1  output beat valid
out_last  out  1  high with bin STORE_LEN-1
out_ready  in  1  consumer accepts the beat
peak_mag  out  DW  peak magnitude of the last good frame, DC excluded
peak_bin  out  AW  bin of peak_mag
frame_done  out  1  1-cycle pulse when a good frame is captured
frame_err  out  1  1-cycle pulse when a malformed frame is detected
drop_cnt  out  8  frames dropped because of overrun; saturates at 255

Behaviour:
- Reset (rst_n=0 at a clk_50m edge): state goes to WAIT_SOP. All outputs are 0, including drop_cnt. Buffer contents are don't-care. Reset mid-frame or mid-drain aborts the operation with no pulse.
- WAIT_SOP:
  - Beats without sop are ignored.
  - A beat with valid&sop writes bin 0, sets bin_cnt=1, clears the running peak (mag=0, bin=0) and moves to CAPTURE.
  - A beat with valid&sop&eop in the same cycle pulses frame_err and stays in WAIT_SOP.
- CAPTURE, on each valid beat with index i=bin_cnt:
  - If i<STORE_LEN, write buffer[i].
  - Peak update applies only when 1<=i<STORE_LEN and mag>running peak. The comparison is strict, so on ties the lower bin wins.
  - If valid&sop arrives, pulse frame_err and restart the frame at this beat (treat it as bin 0).
  - If valid&eop arrives with i==FFT_LEN-1, the frame is good: go to DRAIN.
  - If valid&eop arrives with i!=FFT_LEN-1, pulse frame_err and go to WAIT_SOP.
  - If i==FFT_LEN-1 and eop is absent, pulse frame_err and go to WAIT_SOP.
  - Cycles with data_valid=0 inside a frame are allowed; bin_cnt holds.
- Good-frame timing (eop beat at cycle T):
  - frame_done=1 in cycle T+1 only.
  - peak_mag/peak_bin are updated in T+1 and hold until the next good frame.
  - out_valid is first asserted in T+2 with bin 0. Buffer read latency is 1 cycle.
- DRAIN:
  - Outputs bins 0..STORE_LEN-1 in order. A beat transfers on out_valid&out_ready.
  - While out_valid=1 and out_ready=0, out_data/out_bin/out_last are held stable.
  - With out_ready held high, throughput is 1 beat per cycle with no bubbles. This requires a prefetched read address plus an output/skid register.
  - After the out_last handshake, out_valid=0 in the next cycle and the state returns to WAIT_SOP.
- Overrun:
  - Any valid&sop seen in DRAIN increments drop_cnt (saturating at 255). That frame is ignored entirely, including a sop in the same cycle as the final handshake.
  - Remaining beats of a dropped frame are discarded because WAIT_SOP waits for a fresh sop.
  - frame_err is not asserted for dropped frames.
- Arithmetic:
  - The magnitude compare is unsigned DW-bit.
  - bin_cnt is AW bits and never wraps, because the index check happens at FFT_LEN-1.
- Simultaneous events: frame_done and frame_err can never both be high in the same cycle. A frame_err restart on sop takes precedence over the peak update for that beat.

Test Plan:
1. Good frame, out_ready=1. Stimulus: bin k carries k; bin 0=4095; bin 10=3000. Response: frame_done once at T+1; peak_bin=10, peak_mag=3000 (DC ignored); 64 consecutive beats at T+2..T+65 with out_bin 0..63; out_last on bin 63; out_data[0]=4095.
2. Short frame (eop at index 99), then a good frame. Response: one frame_err pulse, no frame_done and no out_valid for the short frame; the following frame is drained correctly.
3. Backpressure. Stimulus: out_ready toggles 1,0,1,0 during drain. Response: outputs stay stable while ready=0; exactly 64 handshakes, in order, with no duplicates.
4. Overrun. Stimulus: out_ready=0 while frame 2 arrives, then release; frame 3 arrives after the drain. Response: drop_cnt=1; frame 2 is never output; frame 3 is captured and drained normally.
5. Ties. Stimulus: bins 5 and 20 both =2000, all others <2000. Response: peak_bin=5, peak_mag=2000.
6. Reset. Stimulus: rst_n=0 for one edge at capture bin 50. Response: all outputs 0 on the next cycle; no frame_done; the next good frame is captured correctly.
